// File: rtl/queue_write_control_pkg.sv
// Shared queue geometry for the result queue.
// Both the write-side and read-side controllers import these values so that
// depth, pointer width and the almost-full threshold always agree.
package queue_write_control_pkg;

  localparam int QUEUE_DEPTH       = 16;
  localparam int QUEUE_ADDR_W      = 4;
  localparam int QUEUE_AFULL_LEVEL = 14;

  // Sanity helper: true when d is a power of two and at least 4.
  function automatic bit depth_ok(input int d);
    return (d >= 4) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/queue_write_control_occupancy_counter.sv
// Up/down occupancy counter for the result queue.
// Saturates at 0 and DEPTH, and registers full / almost_full / empty
// computed from the next-state count so the flags line up with count.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_inc              one entry written this cycle
//   i_dec              one entry read this cycle
//   o_count            occupancy 0..DEPTH
//   o_full             count == DEPTH
//   o_almost_full      count >= AFULL_LEVEL
//   o_empty            count == 0
module occupancy_counter
  import queue_write_control_pkg::*;
#(
  parameter int DEPTH       = QUEUE_DEPTH,
  parameter int ADDR_W      = QUEUE_ADDR_W,
  parameter int AFULL_LEVEL = QUEUE_AFULL_LEVEL
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AFULL = (ADDR_W + 1)'(AFULL_LEVEL);

  logic [ADDR_W:0] r_count;
  logic            r_full;
  logic            r_almost_full;
  logic            r_empty;
  logic [ADDR_W:0] w_count_nxt;

  // Simultaneous inc and dec cancel; saturation guards both ends.
  always_comb begin
    w_count_nxt = r_count;
    if (i_inc && !i_dec && (r_count != LP_DEPTH)) begin
      w_count_nxt = r_count + (ADDR_W + 1)'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      w_count_nxt = r_count - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_empty       <= 1'b1;
    end else begin
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == LP_DEPTH);
      r_almost_full <= (w_count_nxt >= LP_AFULL);
      r_empty       <= (w_count_nxt == '0);
    end
  end

  assign o_count       = r_count;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;
  assign o_empty       = r_empty;

endmodule

// File: rtl/queue_write_control.sv
// Write-side controller for the comparator's result queue.
// Accepts single-cycle push requests, issues a write strobe with the current
// write pointer whenever the queue has room, tracks occupancy together with
// the read side's rd_en and keeps a sticky overflow flag.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_push             write request (one entry per asserted cycle)
//   i_rd_en            read strobe from the read-side controller
//   i_clr_ovf          clears the sticky overflow flag
//   o_wr_en            write strobe to storage (combinational)
//   o_wr_addr          write pointer (registered)
//   o_count            occupancy 0..DEPTH (registered)
//   o_full             queue full (registered)
//   o_almost_full      occupancy >= AFULL_LEVEL (registered)
//   o_empty            queue empty (registered)
//   o_ovf              sticky: push attempted while full
module queue_write_control
  import queue_write_control_pkg::*;
#(
  parameter int DEPTH       = QUEUE_DEPTH,
  parameter int ADDR_W      = QUEUE_ADDR_W,
  parameter int AFULL_LEVEL = QUEUE_AFULL_LEVEL
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_rd_en,
  input  logic              i_clr_ovf,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_empty,
  output logic              o_ovf
);

  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_ovf;
  logic              w_wr_en;
  logic              w_full;
  logic              w_refused;

  // No bypass: a push while full is refused even if a read frees a slot in
  // the same cycle. Reset also masks the strobe so storage is never written
  // on the reset edge.
  assign w_wr_en   = i_push & ~w_full & ~i_rst;
  assign w_refused = i_push & w_full;

  occupancy_counter #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .AFULL_LEVEL (AFULL_LEVEL)
  ) u_occupancy_counter (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_inc         (w_wr_en),
    .i_dec         (i_rd_en),
    .o_count       (o_count),
    .o_full        (w_full),
    .o_almost_full (o_almost_full),
    .o_empty       (o_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_addr <= '0;
      r_ovf     <= 1'b0;
    end else begin
      // Pointer wraps DEPTH-1 -> 0 through natural ADDR_W overflow.
      if (w_wr_en) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
      end
      // A fresh overflow beats a simultaneous clear.
      if (w_refused) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_wr_en   = w_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_full    = w_full;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_queue_write_control.sv
module tb_queue_write_control;
  import queue_write_control_pkg::*;

  localparam int DEPTH  = QUEUE_DEPTH;
  localparam int ADDR_W = QUEUE_ADDR_W;
  localparam int AFULL  = QUEUE_AFULL_LEVEL;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic              rd_en = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              ovf;

  queue_write_control dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_push        (push),
    .i_rd_en       (rd_en),
    .i_clr_ovf     (clr_ovf),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_count       (count),
    .o_full        (full),
    .o_almost_full (almost_full),
    .o_empty       (empty),
    .o_ovf         (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy as a plain integer, pointer as an integer
  // modulo DEPTH, flags derived from the occupancy by comparison.
  int m_count = 0;
  int m_addr  = 0;
  bit m_ovf   = 0;
  bit started = 0;
  int n_viol  = 0;

  always @(posedge clk) begin
    bit acc;
    bit ref_push;
    if (rst) begin
      m_count = 0;
      m_addr  = 0;
      m_ovf   = 0;
    end else begin
      acc      = push && (m_count < DEPTH);
      ref_push = push && (m_count == DEPTH);
      if (rd_en && m_count == 0) n_viol++;
      if (acc && !rd_en) m_count = m_count + 1;
      else if (rd_en && !acc && m_count > 0) m_count = m_count - 1;
      if (acc) m_addr = (m_addr + 1) % DEPTH;
      if (ref_push) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
    started = 1;
  end

  // Compare process: outputs checked mid-cycle on every cycle after the
  // first edge.
  always @(negedge clk) begin
    if (started) begin
      check("wr_en",       int'(wr_en),       int'(push && !rst && m_count != DEPTH));
      check("wr_addr",     int'(wr_addr),     m_addr);
      check("count",       int'(count),       m_count);
      check("full",        int'(full),        int'(m_count == DEPTH));
      check("almost_full", int'(almost_full), int'(m_count >= AFULL));
      check("empty",       int'(empty),       int'(m_count == 0));
      check("ovf",         int'(ovf),         int'(m_ovf));
    end
  end

  task automatic cyc(input bit p, input bit r, input bit c);
    push = p; rd_en = r; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with push held high: strobe must stay low.
    rst = 1'b1; push = 1'b1;
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    @(posedge clk); #1;
    push = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_addr",  int'(wr_addr), 0);

    // 16 consecutive pushes.
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0);
      if (i == 1)  check("empty_after_1", int'(empty), 0);
      if (i == 13) check("afull_after_13", int'(almost_full), 0);
      if (i == 14) check("afull_after_14", int'(almost_full), 1);
      if (i == 15) check("full_after_15", int'(full), 0);
    end
    push = 0;
    check("fill_count", int'(count), 16);
    check("fill_full",  int'(full), 1);
    check("fill_addr",  int'(wr_addr), 0);

    // Push while full for 2 cycles.
    push = 1; #1;
    check("full_wr_en", int'(wr_en), 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    push = 0;
    check("ovf_set", int'(ovf), 1);
    check("ovf_count", int'(count), 16);
    cyc(0, 0, 1);
    check("ovf_clr", int'(ovf), 0);

    // Push and read together at full: refused, count drops.
    cyc(1, 1, 0);
    check("pr_count", int'(count), 15);
    check("pr_full",  int'(full), 0);
    check("pr_ovf",   int'(ovf), 1);
    push = 1; rd_en = 0; #1;
    check("pr_next_wr_en", int'(wr_en), 1);
    check("pr_next_addr",  int'(wr_addr), 0);
    cyc(1, 0, 1);
    push = 0; clr_ovf = 0;
    check("pr_refill", int'(count), 16);
    check("pr_ovf_clr", int'(ovf), 0);

    // Drain down to 5, then 10 cycles of simultaneous push and read.
    for (int i = 0; i < 11; i++) cyc(0, 1, 0);
    check("drain5_count", int'(count), 5);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    push = 0; rd_en = 0;
    check("pr10_count", int'(count), 5);
    check("pr10_addr",  int'(wr_addr), 11);

    // Drain, write 3, read 3, then one illegal read at empty.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    check("w3_count", int'(count), 3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    check("r3_count", int'(count), 0);
    check("r3_empty", int'(empty), 1);
    check("no_viol_yet", n_viol, 0);
    cyc(0, 1, 0);
    rd_en = 0;
    check("underflow_count", int'(count), 0);
    check("viol_flagged", n_viol, 1);

    // Reset mid-operation with count 9 and push high.
    for (int i = 0; i < 9; i++) cyc(1, 0, 0);
    check("pre_rst_count", int'(count), 9);
    rst = 1; push = 1; #1;
    check("mid_rst_wr_en", int'(wr_en), 0);
    @(posedge clk); #1;
    rst = 0; push = 0;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_addr",  int'(wr_addr), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_full",  int'(full), 0);
    check("mid_rst_ovf",   int'(ovf), 0);
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
